sid_reg_recorder: RTL and testbench

- Records SID register writes and encodes them into the player command stream: 5-bit address + 8-bit data entries, with address 5'h1f (`DELAY_CMD`) carrying an idle-cycle count.
- Placed in parallel with `sid8580`, tapping its `we`/`addr`/`data_in`/`ce_1m`. It buffers the encoded entries in an internal FIFO for a downstream sink (UART dumper, capture RAM).
- It is the encoder for the ROM-driven player: replaying its output reproduces the recorded register write sequence and its spacing in SID cycles.

---
 rtl/sid_reg_recorder.sv | 235 +++++++++++++++++++++++
 tb/tb_sid_reg_recorder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sid_reg_recorder.sv
// sid_reg_recorder: taps SID register writes and encodes them into the player
// command stream.  Each entry is a 5-bit address plus 8-bit data.  An entry whose
// address is DELAY_CMD carries a count of idle SID cycles instead of a register write.
//
// Ports:
//   clk, reset (sync, active-high)       - clock and reset
//   ce_1m, we, addr, data_in             - SID cycle enable and write tap
//   entry_valid/entry_addr/entry_data    - FIFO head, first-word-fall-through
//   entry_ready                          - sink accept; pops the head entry
//   fifo_level                           - number of entries held
//   overflow                             - sticky; a push was dropped on a full FIFO
//   illegal_addr                         - sticky; a write to DELAY_CMD was seen
//
// Optional feature: define SID_REC_DEDUP_EN to drop writes that repeat the last
// recorded value of registers 0x00-0x1c.  A dropped write counts as an idle tick.
module sid_reg_recorder #(
   parameter int          FIFO_DEPTH = 16,
   parameter logic [4:0]  DELAY_CMD  = 5'h1f,
   parameter int          MAX_DELAY  = 255
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          ce_1m,
   input  logic                          we,
   input  logic [4:0]                    addr,
   input  logic [7:0]                    data_in,
   output logic                          entry_valid,
   output logic [4:0]                    entry_addr,
   output logic [7:0]                    entry_data,
   input  logic                          entry_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow,
   output logic                          illegal_addr
);

   localparam int         AW          = $clog2(FIFO_DEPTH);
   localparam logic [7:0] MAX_DELAY_C = 8'(MAX_DELAY);

   typedef enum logic [1:0] {
      S_IDLE       = 2'd0,
      S_EMIT_DELAY = 2'd1,
      S_EMIT_WRITE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  idle_cnt_q, idle_cnt_d;
   logic [4:0]  pend_addr_q;
   logic [7:0]  pend_data_q;
   logic        flush_q, flush_d;
   logic        overflow_q, illegal_q;

   logic        dup;
   logic        cap;
   logic        idle_tick;
   logic [7:0]  idle_inc;

   logic        push_vld;
   logic [4:0]  push_addr;
   logic [7:0]  push_data;
   logic        push_ok;
   logic        pop;
   logic        full;

   logic [12:0] mem_q [0:FIFO_DEPTH-1];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   level_q;

   // ------------------------------------------------------------------
   // Duplicate-write suppression
   // ------------------------------------------------------------------
`ifdef SID_REC_DEDUP_EN
   logic [7:0] shadow_q [0:28];

   always_comb begin
      dup = 1'b0;
      if (addr <= 5'h1c) begin
         dup = (shadow_q[addr] == data_in);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 29; i++) begin
            shadow_q[i] <= 8'h00;
         end
      end else if (cap && (addr <= 5'h1c)) begin
         shadow_q[addr] <= data_in;
      end
   end
`else
   assign dup = 1'b0;
`endif

   // Only IDLE captures; the ce_1m spacing ensures we are back in IDLE
   // before the next pulse, so a tick outside IDLE can only be idle.
   assign cap       = ce_1m && we && (addr != DELAY_CMD) && !dup && (state_q == S_IDLE);
   assign idle_tick = ce_1m && !cap;
   assign idle_inc  = idle_cnt_q + 8'd1;

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         pend_addr_q <= 5'h00;
         pend_data_q <= 8'h00;
      end else begin
         state_q <= state_d;
         if (cap) begin
            pend_addr_q <= addr;
            pend_data_q <= data_in;
         end
      end
   end

   // FSM: next state.  With no idle time to report, EMIT_DELAY emits the
   // write itself, so the write reaches the FIFO one clk earlier.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:       if (cap) state_d = S_EMIT_DELAY;
         S_EMIT_DELAY: state_d = (idle_cnt_q != 8'd0) ? S_EMIT_WRITE : S_IDLE;
         S_EMIT_WRITE: state_d = S_IDLE;
         default:      state_d = S_IDLE;
      endcase
   end

   // FSM: outputs (the single FIFO push port).  A saturation flush never
   // overlaps an emit state because a write tick does not advance idle_cnt.
   always_comb begin
      push_vld  = 1'b0;
      push_addr = 5'h00;
      push_data = 8'h00;
      if (flush_q) begin
         push_vld  = 1'b1;
         push_addr = DELAY_CMD;
         push_data = MAX_DELAY_C;
      end else begin
         case (state_q)
            S_EMIT_DELAY: begin
               push_vld = 1'b1;
               if (idle_cnt_q != 8'd0) begin
                  push_addr = DELAY_CMD;
                  push_data = idle_cnt_q;
               end else begin
                  push_addr = pend_addr_q;
                  push_data = pend_data_q;
               end
            end
            S_EMIT_WRITE: begin
               push_vld  = 1'b1;
               push_addr = pend_addr_q;
               push_data = pend_data_q;
            end
            default: ;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Idle counter and saturation flush
   // ------------------------------------------------------------------
   always_comb begin
      idle_cnt_d = idle_cnt_q;
      flush_d    = 1'b0;
      if (state_q == S_EMIT_DELAY) begin
         idle_cnt_d = 8'd0;
      end else if (idle_tick) begin
         if (idle_inc == MAX_DELAY_C) begin
            idle_cnt_d = 8'd0;
            flush_d    = 1'b1;
         end else begin
            idle_cnt_d = idle_inc;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idle_cnt_q <= 8'd0;
         flush_q    <= 1'b0;
         illegal_q  <= 1'b0;
      end else begin
         idle_cnt_q <= idle_cnt_d;
         flush_q    <= flush_d;
         if (ce_1m && we && (addr == DELAY_CMD)) begin
            illegal_q <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Entry FIFO (first-word-fall-through)
   // ------------------------------------------------------------------
   assign full    = (level_q == (AW+1)'(FIFO_DEPTH));
   assign pop     = (level_q != '0) && entry_ready;
   // A pop in the same clk frees the slot a push into a full FIFO needs.
   assign push_ok = push_vld && (!full || pop);

   always_ff @(posedge clk) begin
      if (push_ok && !reset) begin
         mem_q[wr_ptr_q] <= {push_addr, push_data};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push_ok, pop})
            2'b10:   level_q <= level_q + (AW+1)'(1);
            2'b01:   level_q <= level_q - (AW+1)'(1);
            default: level_q <= level_q;
         endcase
         if (push_vld && !push_ok) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // Head outputs are forced to zero while empty so stale RAM never shows.
   assign entry_valid  = (level_q != '0);
   assign entry_addr   = entry_valid ? mem_q[rd_ptr_q][12:8] : 5'h00;
   assign entry_data   = entry_valid ? mem_q[rd_ptr_q][7:0]  : 8'h00;
   assign fifo_level   = level_q;
   assign overflow     = overflow_q;
   assign illegal_addr = illegal_q;

endmodule

// File: tb/tb_sid_reg_recorder.sv
module tb_sid_reg_recorder;

   logic        clk = 1'b0;
   logic        reset;
   logic        ce_1m;
   logic        we;
   logic [4:0]  addr;
   logic [7:0]  data_in;
   logic        entry_valid;
   logic [4:0]  entry_addr;
   logic [7:0]  entry_data;
   logic        entry_ready;
   logic [4:0]  fifo_level;
   logic        overflow;
   logic        illegal_addr;

   always #5 clk = ~clk;

   sid_reg_recorder dut (
      .clk          (clk),
      .reset        (reset),
      .ce_1m        (ce_1m),
      .we           (we),
      .addr         (addr),
      .data_in      (data_in),
      .entry_valid  (entry_valid),
      .entry_addr   (entry_addr),
      .entry_data   (entry_data),
      .entry_ready  (entry_ready),
      .fifo_level   (fifo_level),
      .overflow     (overflow),
      .illegal_addr (illegal_addr)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: the encoded stream as a queue of {addr,data}
   logic [12:0] exp_q[$];
   logic [12:0] got_q[$];
   int          m_idle;
   bit          m_ill;
   bit          m_ovf;
   bit          hold_mode;
   bit          rand_rdy;
   logic [7:0]  m_shadow [0:28];

   always @(negedge clk) begin
      if (!reset && entry_valid && entry_ready) got_q.push_back({entry_addr, entry_data});
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_idle = 0;
      m_ill  = 0;
      m_ovf  = 0;
      for (int i = 0; i < 29; i++) m_shadow[i] = 8'h00;
      exp_q.delete();
      got_q.delete();
   endfunction

   function automatic void m_push(logic [12:0] e);
      if (hold_mode && exp_q.size() >= 16) m_ovf = 1;
      else exp_q.push_back(e);
   endfunction

   function automatic void model_tick(bit w, logic [4:0] a, logic [7:0] d);
      bit rec;
      rec = w && (a != 5'h1f);
      if (w && a == 5'h1f) m_ill = 1;
`ifdef SID_REC_DEDUP_EN
      if (rec && a <= 5'd28) begin
         if (m_shadow[a] == d) rec = 0;
         else m_shadow[a] = d;
      end
`endif
      if (rec) begin
         if (m_idle != 0) m_push({5'h1f, 8'(m_idle)});
         m_push({a, d});
         m_idle = 0;
      end else begin
         m_idle++;
         if (m_idle == 255) begin
            m_push({5'h1f, 8'hff});
            m_idle = 0;
         end
      end
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
      if (rand_rdy) entry_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic tick(bit w, logic [4:0] a, logic [7:0] d, int gap);
      ce_1m = 1'b1; we = w; addr = a; data_in = d;
      model_tick(w, a, d);
      cyc();
      ce_1m = 1'b0; we = 1'b0;
      repeat (gap - 1) cyc();
   endtask

   task automatic drain_cmp(string tag);
      int n;
      int sz;
      rand_rdy    = 0;
      entry_ready = 1'b1;
      n = 0;
      repeat (3) cyc();
      while (entry_valid && n < 100) begin
         cyc();
         n++;
      end
      chk({tag, "_drained"}, 32'(entry_valid), 32'd0);
      chk({tag, "_count"}, got_q.size(), exp_q.size());
      sz = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < sz; i++) chk($sformatf("%s_e%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
   endtask

   task automatic clear_q();
      exp_q.delete();
      got_q.delete();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc(); cyc();
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      reset = 1'b1; ce_1m = 1'b0; we = 1'b0; addr = '0; data_in = '0;
      entry_ready = 1'b0; hold_mode = 0; rand_rdy = 0;
      model_reset();
      cyc(); cyc();
      chk("rst_valid", 32'(entry_valid), 32'd0);
      chk("rst_addr", 32'(entry_addr), 32'd0);
      chk("rst_data", 32'(entry_data), 32'd0);
      chk("rst_level", 32'(fifo_level), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_illegal", 32'(illegal_addr), 32'd0);
      reset = 1'b0;
      cyc();

      // Three idle ticks then a write
      repeat (3) tick(0, 5'h00, 8'h00, 3);
      tick(1, 5'h04, 8'h41, 3);
      chk("t1_level", 32'(fifo_level), 32'd2);
      chk("t1_head", 32'({entry_addr, entry_data}), 32'h1f03);
      drain_cmp("t1");
      chk("t1_c0", 32'(got_q[0]), 32'h1f03);
      chk("t1_c1", 32'(got_q[1]), 32'h0441);
      clear_q();

      // Back-to-back writes; first one lands one clk after capture
      entry_ready = 1'b0;
      ce_1m = 1'b1; we = 1'b1; addr = 5'h00; data_in = 8'h12;
      model_tick(1, 5'h00, 8'h12);
      cyc();
      ce_1m = 1'b0; we = 1'b0;
      chk("t2_lat_before", 32'(fifo_level), 32'd0);
      cyc();
      chk("t2_lat_after", 32'(fifo_level), 32'd1);
      cyc();
      tick(1, 5'h01, 8'h34, 3);
      drain_cmp("t2");
      chk("t2_c0", 32'(got_q[0]), 32'h0012);
      chk("t2_c1", 32'(got_q[1]), 32'h0134);
      clear_q();

      // 300 idle ticks: one saturated delay plus the remainder
      repeat (300) tick(0, 5'h00, 8'h00, 3);
      tick(1, 5'h18, 8'h0f, 3);
      drain_cmp("t3");
      chk("t3_c0", 32'(got_q[0]), 32'h1fff);
      chk("t3_c1", 32'(got_q[1]), 32'h1f2d);
      chk("t3_c2", 32'(got_q[2]), 32'h180f);
      clear_q();

      // Sink stalled: 20 writes into a 16-deep FIFO
      hold_mode   = 1;
      entry_ready = 1'b0;
      for (int i = 0; i < 20; i++) tick(1, 5'(i), 8'(8'h80 + i), 3);
      repeat (2) cyc();
      chk("t4_level", 32'(fifo_level), 32'd16);
      chk("t4_overflow", 32'(overflow), 32'(m_ovf));
      chk("t4_overflow_const", 32'(overflow), 32'd1);
      drain_cmp("t4");
      chk("t4_first", 32'(got_q[0]), 32'h0080);
      chk("t4_last", 32'(got_q[15]), 32'h0f8f);
      hold_mode = 0;
      clear_q();

      // Reset with entries queued and a write pending
      entry_ready = 1'b0;
      tick(1, 5'h02, 8'h55, 3);
      ce_1m = 1'b1; we = 1'b1; addr = 5'h03; data_in = 8'h77;
      cyc();
      ce_1m = 1'b0; we = 1'b0;
      do_reset();
      chk("mid_rst_level", 32'(fifo_level), 32'd0);
      chk("mid_rst_overflow", 32'(overflow), 32'd0);
      repeat (4) cyc();
      chk("mid_rst_pending_dropped", 32'(fifo_level), 32'd0);
      chk("mid_rst_valid", 32'(entry_valid), 32'd0);

      // Write to DELAY_CMD counts as idle
      tick(1, 5'h1f, 8'haa, 3);
      tick(0, 5'h00, 8'h00, 3);
      tick(1, 5'h05, 8'h09, 3);
      chk("t5_illegal", 32'(illegal_addr), 32'd1);
      drain_cmp("t5");
      chk("t5_c0", 32'(got_q[0]), 32'h1f02);
      chk("t5_c1", 32'(got_q[1]), 32'h0509);
      clear_q();

      // Repeated identical write
      do_reset();
      tick(1, 5'h04, 8'h41, 3);
      tick(1, 5'h04, 8'h41, 3);
      drain_cmp("t6");
`ifdef SID_REC_DEDUP_EN
      chk("t6_entries", got_q.size(), 32'd1);
`else
      chk("t6_entries", got_q.size(), 32'd2);
`endif
      clear_q();
      tick(1, 5'h06, 8'h01, 3);
      drain_cmp("t6b");
      clear_q();

      // Randomized traffic with a randomly stalling sink
      do_reset();
      rand_rdy = 1;
      repeat (300) begin
         bit          w;
         logic [4:0]  a;
         logic [7:0]  d;
         w = 1'($urandom_range(0, 1));
         a = 5'($urandom_range(0, 31));
         d = 8'($urandom_range(0, 3));
         tick(w, a, d, $urandom_range(3, 6));
      end
      drain_cmp("rnd");
      chk("rnd_overflow", 32'(overflow), 32'd0);
      chk("rnd_illegal", 32'(illegal_addr), 32'(m_ill));
      clear_q();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
